// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO registers.
// Optional multiply-accumulate ops (7-10) are enabled by defining MDU_MADD_EN.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sel,
    output logic [WIDTH-1:0] Out,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     hi_reg, hi_next, lo_reg, lo_next;
    logic [2*WIDTH-1:0]   prod_reg, prod_next;
    logic [WIDTH-1:0]     mcand_reg, mcand_next;
    logic [WIDTH-1:0]     rem_reg, rem_next, quot_reg, quot_next;
    logic [WIDTH-1:0]     divisor_reg, divisor_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 neg_res_reg, neg_res_next, neg_rem_reg, neg_rem_next;
    logic                 div_zero_reg, div_zero_next, is_div_reg, is_div_next;
`ifdef MDU_MADD_EN
    logic                 acc_en_reg, acc_en_next, acc_sub_reg, acc_sub_next;
    logic [2*WIDTH-1:0]   acc_sum;
`endif

    logic                 op_mul, op_div, op_sgn, op_acc, op_sub;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0]   prod_fix, result_fix;

    always_comb begin
        op_mul = (Op == 4'd1) || (Op == 4'd2);
        op_div = (Op == 4'd3) || (Op == 4'd4);
        op_sgn = (Op == 4'd1) || (Op == 4'd3);
        op_acc = 1'b0;
        op_sub = 1'b0;
`ifdef MDU_MADD_EN
        op_acc = (Op >= 4'd7) && (Op <= 4'd10);
        op_sub = (Op == 4'd9) || (Op == 4'd10);
        op_mul = op_mul || op_acc;
        op_sgn = op_sgn || (Op == 4'd7) || (Op == 4'd9);
`endif
    end

    assign a_abs = (op_sgn && A[WIDTH-1]) ? -A : A;
    assign b_abs = (op_sgn && B[WIDTH-1]) ? -B : B;

    // Shift-add: conditionally add multiplicand into the upper half, keep the carry.
    assign mul_sum = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                     {1'b0, (prod_reg[0] ? mcand_reg : {WIDTH{1'b0}})};

    // Remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
    // and bit WIDTH of the trial difference is a valid borrow flag.
    assign div_shift = {rem_reg, quot_reg[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, divisor_reg};

    assign prod_fix = neg_res_reg ? -prod_reg : prod_reg;
`ifdef MDU_MADD_EN
    assign acc_sum    = acc_sub_reg ? ({hi_reg, lo_reg} - prod_fix) : ({hi_reg, lo_reg} + prod_fix);
    assign result_fix = acc_en_reg ? acc_sum : prod_fix;
`else
    assign result_fix = prod_fix;
`endif

    always_comb begin
        state_next    = state_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        prod_next     = prod_reg;
        mcand_next    = mcand_reg;
        rem_next      = rem_reg;
        quot_next     = quot_reg;
        divisor_next  = divisor_reg;
        cnt_next      = cnt_reg;
        neg_res_next  = neg_res_reg;
        neg_rem_next  = neg_rem_reg;
        div_zero_next = div_zero_reg;
        is_div_next   = is_div_reg;
`ifdef MDU_MADD_EN
        acc_en_next   = acc_en_reg;
        acc_sub_next  = acc_sub_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    if (Op == 4'd5) lo_next = A;
                    if (Op == 4'd6) hi_next = A;
                    if (op_mul || op_div) begin
                        cnt_next     = '0;
                        neg_res_next = op_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem_next = op_sgn && A[WIDTH-1];
                        is_div_next  = op_div;
                    end
                    if (op_mul) begin
                        prod_next  = {{WIDTH{1'b0}}, b_abs};
                        mcand_next = a_abs;
                        state_next = MUL;
`ifdef MDU_MADD_EN
                        acc_en_next  = op_acc;
                        acc_sub_next = op_sub;
`endif
                    end
                    if (op_div) begin
                        quot_next     = a_abs;
                        rem_next      = '0;
                        divisor_next  = b_abs;
                        div_zero_next = (B == '0);
                        state_next    = DIV;
                    end
                end
            end
            MUL: begin
                prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
            end
            DIV: begin
                if (!div_trial[WIDTH]) begin
                    rem_next  = div_trial[WIDTH-1:0];
                    quot_next = {quot_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_next  = div_shift[WIDTH-1:0];
                    quot_next = {quot_reg[WIDTH-2:0], 1'b0};
                end
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                if (is_div_reg) begin
                    if (!div_zero_reg) begin
                        lo_next = neg_res_reg ? -quot_reg : quot_reg;
                        hi_next = neg_rem_reg ? -rem_reg : rem_reg;
                    end
                end else begin
                    {hi_next, lo_next} = result_fix;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            hi_reg       <= '0;
            lo_reg       <= '0;
            prod_reg     <= '0;
            mcand_reg    <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            divisor_reg  <= '0;
            cnt_reg      <= '0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            is_div_reg   <= 1'b0;
`ifdef MDU_MADD_EN
            acc_en_reg   <= 1'b0;
            acc_sub_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            prod_reg     <= prod_next;
            mcand_reg    <= mcand_next;
            rem_reg      <= rem_next;
            quot_reg     <= quot_next;
            divisor_reg  <= divisor_next;
            cnt_reg      <= cnt_next;
            neg_res_reg  <= neg_res_next;
            neg_rem_reg  <= neg_rem_next;
            div_zero_reg <= div_zero_next;
            is_div_reg   <= is_div_next;
`ifdef MDU_MADD_EN
            acc_en_reg   <= acc_en_next;
            acc_sub_reg  <= acc_sub_next;
`endif
        end
    end

    assign Out  = Sel ? hi_reg : lo_reg;
    assign Busy = (state_reg != IDLE);
    assign Done = (state_reg == FIX);
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed test-plan cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         Start = 1'b0;
    logic [3:0]   Op = 4'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Sel = 1'b0;
    logic [W-1:0] Out;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Sel(Sel), .Out(Out), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit madd_en();
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_busy_op(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (madd_en() && op >= 4'd7 && op <= 4'd10);
    endfunction

    // Reference: new {HI,LO} from the architectural definition of each op.
    function automatic logic [63:0] model_next(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [63:0] hl);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return sa * sb;
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 0) return hl;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 0) return hl;
                return {32'(ua % ub), 32'(ua / ub)};
            end
            4'd5: return {hl[63:32], a};
            4'd6: return {a, hl[31:0]};
            4'd7: begin p = sa * sb; return madd_en() ? hl + p : hl; end
            4'd8: begin p = ua * ub; return madd_en() ? hl + p : hl; end
            4'd9: begin p = sa * sb; return madd_en() ? hl - p : hl; end
            4'd10: begin p = ua * ub; return madd_en() ? hl - p : hl; end
            default: return hl;
        endcase
    endfunction

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        Sel = 1'b0; #1; lo = Out;
        Sel = 1'b1; #1; hi = Out;
        Sel = 1'b0;
    endtask

    // Issue one op; optionally inject ignored starts at a busy cycle or reset mid-op.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inject, input int rst_at);
        int cycles = 0, dones = 0, done_at = 0;
        bit aborted = 0;
        logic [W-1:0] hi, lo;
        logic [63:0] expv;
        expv = model_next(op, a, b, {model_hi, model_lo});
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0;
        if (!is_busy_op(op)) begin
            check({tag, " nobusy"}, {63'd0, Busy}, 64'd0);
            check({tag, " nodone"}, {63'd0, Done}, 64'd0);
        end else begin
            check({tag, " old_lo_during_busy"}, {32'd0, Out}, {32'd0, model_lo});
            while (Busy && cycles < 200) begin
                cycles++;
                if (Done) begin dones++; done_at = cycles; end
                if (inject != 0 && cycles == inject) begin
                    Start = 1'b1; Op = 4'd6; A = 32'hDEAD;
                end else if (inject != 0 && cycles == inject + 1) begin
                    Start = 1'b1; Op = 4'd4; A = 32'd100; B = 32'd7;
                end
                if (rst_at != 0 && cycles == rst_at) rst = 1'b1;
                @(posedge clk); #1;
                Start = 1'b0;
                if (rst) begin
                    rst = 1'b0;
                    aborted = 1;
                    check({tag, " busy_after_rst"}, {63'd0, Busy}, 64'd0);
                    check({tag, " done_after_rst"}, {63'd0, Done}, 64'd0);
                    model_hi = '0; model_lo = '0;
                    break;
                end
            end
            if (aborted) begin
                check({tag, " dones_before_rst"}, 64'(dones), 64'd0);
            end else begin
                check({tag, " busy_cycles"}, 64'(cycles), 64'(W + 1));
                check({tag, " done_count"}, 64'(dones), 64'd1);
                check({tag, " done_cycle"}, 64'(done_at), 64'(W + 1));
            end
        end
        if (!aborted) {model_hi, model_lo} = expv;
        read_hilo(hi, lo);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, model_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, model_lo});
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, a, b, hi, lo);
    endtask

    initial begin
        logic [W-1:0] hi, lo, ra, rb;
        logic [3:0] rop;
        logic [3:0] ops [8];
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};

        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        check("reset busy", {63'd0, Busy}, 64'd0);
        check("reset done", {63'd0, Done}, 64'd0);
        read_hilo(hi, lo);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);

        run_op("mult", 4'd1, 32'hFFFFFFFE, 32'h3, 0, 0);
        check("mult hi const", {32'd0, model_hi}, 64'hFFFFFFFF);
        run_op("multu", 4'd2, 32'hFFFFFFFE, 32'h3, 0, 0);
        check("multu hi const", {32'd0, model_hi}, 64'h2);
        run_op("divu", 4'd4, 32'd100, 32'd7, 0, 0);
        run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 0, 0);
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        check("div_ovf lo const", {32'd0, model_lo}, 64'h80000000);

        run_op("mthi", 4'd6, 32'h1234, 32'd0, 0, 0);
        run_op("mtlo", 4'd5, 32'h5678, 32'd0, 0, 0);
        run_op("divu_zero", 4'd4, 32'd55, 32'd0, 0, 0);
        run_op("noop0", 4'd0, 32'hAAAA, 32'd1, 0, 0);
        run_op("noop13", 4'd13, 32'hBBBB, 32'd1, 0, 0);

        run_op("mthi0", 4'd6, 32'd0, 32'd0, 0, 0);
        run_op("multu_inj", 4'd2, 32'd5, 32'd6, 3, 0);
        check("inj lo const", {32'd0, model_lo}, 64'd30);

        run_op("mult_rst", 4'd1, 32'h1234567, 32'h89ABC, 0, 10);
        run_op("multu_after", 4'd2, 32'd3, 32'd4, 0, 0);

        run_op("mthi_m", 4'd6, 32'd0, 32'd0, 0, 0);
        run_op("mtlo_m", 4'd5, 32'hFFFFFFFF, 32'd0, 0, 0);
        run_op("maddu", 4'd8, 32'd1, 32'd1, 0, 0);
        run_op("mtlo_z", 4'd5, 32'd0, 32'd0, 0, 0);
        run_op("mthi_z", 4'd6, 32'd0, 32'd0, 0, 0);
        run_op("msub", 4'd9, 32'hFFFFFFFF, 32'd1, 0, 0);

        for (int i = 0; i < 24; i++) begin
            rop = ops[$urandom_range(0, 7)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            run_op($sformatf("rand%0d", i), rop, ra, rb, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the pipeline EX stage; successor to the fixed-latency behavioural MDU.
- Real radix-2 shift-add multiplier and restoring divider, WIDTH cycles per operation, with HI/LO architectural registers.
- Busy/Done handshake lets the hazard unit stall mfhi/mflo and subsequent MDU ops.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be >= 4.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- Start  input  1  issue strobe; Op/A/B sampled on the edge where Start=1 and Busy=0
- Op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 no-op
- A  input  WIDTH  rs operand
- B  input  WIDTH  rt operand
- Sel  input  1  0 selects LO, 1 selects HI on Out
- Out  output  WIDTH  combinational Sel ? HI : LO
- Busy  output  1  high while an iterative op is in flight
- Done  output  1  one-cycle pulse on the cycle HI/LO take the result

Behaviour:
- Reset: HI=0, LO=0, Busy=0, Done=0, state IDLE, counter 0, internal accumulators 0.
- Reset mid-operation aborts immediately. HI/LO are cleared and no Done is produced.
- States: IDLE, MUL, DIV, FIX.
- mtlo/mthi (Op 5/6): take effect when Start=1 and Busy=0. LO<=A or HI<=A on that edge. No Busy, no Done.
- Mult/div issue (Op 1-4, 7-10 with Start=1, Busy=0):
  - Latch |A|, |B| for signed ops (raw values for unsigned) and the result sign flags.
  - Clear the counter. Go to MUL or DIV. Busy=1 from the next cycle.
- MUL:
  - Each cycle: if multiplier LSB=1, add multiplicand into the upper half of a 2*WIDTH product register; shift right 1.
  - After WIDTH iterations go to FIX.
- DIV:
  - Restoring step each cycle: shift {rem,quot} left 1; trial-subtract divisor from rem; keep the result if non-negative and set the quotient bit.
  - After WIDTH iterations go to FIX.
- FIX (1 cycle):
  - Negate the product if signs differ.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO, pulse Done, return to IDLE, Busy=0 on the following cycle.
- Latency: Busy high exactly WIDTH+1 cycles (33 at WIDTH=32). Done coincides with the last Busy cycle. The result is visible on Out the cycle after Done.
- Divide by zero (B=0): runs full latency; Done pulses, HI/LO left unchanged.
- Signed overflow: MIN/-1 gives LO=MIN (0x80000000), HI=0, from natural wrap.
- While Busy: Start is ignored, including mtlo/mthi. The stall logic guarantees none are issued; the block must still ignore them.
- Out during Busy shows the old HI/LO values.
- Start with Op 0 or 11-15: no state change.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - Op 7/8 add the signed/unsigned product to {HI,LO}; Op 9/10 subtract it. Arithmetic is modulo 2^(2*WIDTH).
  - The add/subtract is performed in FIX, so latency is the same as mult.
- Undefined: Op 7-10 behave as no-op (no Busy, HI/LO unchanged). The accumulate adder is not synthesised.

Test Plan:
- mult A=0xFFFFFFFE B=0x00000003 -> Busy high 33 cycles, Done on the 33rd; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- divu A=100 B=7 -> LO=14, HI=2. div A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload mthi 0x1234, mtlo 0x5678; divu B=0 -> Done pulses after 33 cycles, HI=0x1234, LO=0x5678 unchanged.
- Issue multu 5*6; then on cycle 3 of Busy issue Start with mthi A=0xDEAD and divu -> both ignored; final HI=0, LO=30; Busy falls on schedule.
- Issue mult, assert rst on Busy cycle 10 -> next cycle Busy=0, HI=LO=0, no Done; a fresh multu 3*4 afterwards gives LO=12.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF; maddu 1*1 -> HI=1, LO=0. msub -1*1 from {0,0} -> HI=0, LO=1. Without the macro: same ops leave HI/LO unchanged, Busy stays 0.
